// File: rtl/sobel_edge_detect_if.sv
// rtl/sobel_edge_detect_if.sv - pixel stream in/out signal bundle for sobel_edge_detect
interface sobel_edge_detect_if;
  logic       per_frame_vsync;
  logic       per_frame_href;
  logic       per_frame_clken;
  logic [7:0] row1_data;
  logic [7:0] row2_data;
  logic [7:0] row3_data;
  logic       post_frame_vsync;
  logic       post_frame_href;
  logic       post_frame_clken;
  logic [7:0] post_img_mag;
  logic [7:0] post_img_bit;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken,
    output row1_data, row2_data, row3_data,
    input  post_frame_vsync, post_frame_href, post_frame_clken,
    input  post_img_mag, post_img_bit
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken,
    input  row1_data, row2_data, row3_data,
    output post_frame_vsync, post_frame_href, post_frame_clken,
    output post_img_mag, post_img_bit
  );
endinterface

// File: rtl/sobel_edge_detect.sv
// rtl/sobel_edge_detect.sv - 3x3 Sobel gradient magnitude with edge threshold, 4-clock pipeline
// Stages: window shift, Gx/Gy, |Gx|+|Gy|, saturate/threshold with border forcing.
module sobel_edge_detect #(
  parameter logic [10:0] THRESHOLD  = 11'd40,
  parameter int          LINE_CNT_W = 11
) (
  input logic                clock,
  input logic                sys_rst_n,
  sobel_edge_detect_if.slave bus
);

  logic [7:0] p11, p12, p13;
  logic [7:0] p21, p22, p23;
  logic [7:0] p31, p32, p33;

  always_ff @(posedge clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      {p11, p12, p13} <= '0;
      {p21, p22, p23} <= '0;
      {p31, p32, p33} <= '0;
    end else if (!bus.per_frame_href) begin
      {p11, p12, p13} <= '0;
      {p21, p22, p23} <= '0;
      {p31, p32, p33} <= '0;
    end else if (bus.per_frame_clken) begin
      {p11, p12, p13} <= {p12, p13, bus.row1_data};
      {p21, p22, p23} <= {p22, p23, bus.row2_data};
      {p31, p32, p33} <= {p32, p33, bus.row3_data};
    end
  end

  logic [LINE_CNT_W-1:0] col_cnt;
  logic [LINE_CNT_W-1:0] row_cnt;
  logic                  href_d;

  always_ff @(posedge clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
      href_d  <= 1'b0;
    end else begin
      href_d <= bus.per_frame_href;
      if (!bus.per_frame_href)
        col_cnt <= '0;
      else if (bus.per_frame_clken && col_cnt != '1)
        col_cnt <= col_cnt + 1'b1;
      if (!bus.per_frame_vsync)
        row_cnt <= '0;
      else if (href_d && !bus.per_frame_href && row_cnt != '1)
        row_cnt <= row_cnt + 1'b1;
    end
  end

  // Counters still hold the index of the pixel being accepted on this clock.
  logic border_in;
  assign border_in = ~bus.per_frame_href
                   | (col_cnt < LINE_CNT_W'(2))
                   | (row_cnt < LINE_CNT_W'(2));

  logic [9:0] gx_pos, gx_neg, gy_pos, gy_neg;

  always_comb begin
    gx_pos = 10'(p13) + {1'b0, p23, 1'b0} + 10'(p33);
    gx_neg = 10'(p11) + {1'b0, p21, 1'b0} + 10'(p31);
    gy_pos = 10'(p11) + {1'b0, p12, 1'b0} + 10'(p13);
    gy_neg = 10'(p31) + {1'b0, p32, 1'b0} + 10'(p33);
  end

  logic signed [10:0] gx, gy;
  logic        [10:0] abs_gx, abs_gy;
  logic        [10:0] mag;

  always_comb begin
    abs_gx = gx[10] ? 11'(-gx) : 11'(gx);
    abs_gy = gy[10] ? 11'(-gy) : 11'(gy);
  end

  logic [3:0] vsync_s, href_s, clken_s;
  logic [2:0] border_s;
  logic [7:0] mag_out, bit_out;

  always_ff @(posedge clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gx       <= '0;
      gy       <= '0;
      mag      <= '0;
      vsync_s  <= '0;
      href_s   <= '0;
      clken_s  <= '0;
      border_s <= '0;
      mag_out  <= '0;
      bit_out  <= '0;
    end else begin
      gx       <= $signed({1'b0, gx_pos} - {1'b0, gx_neg});
      gy       <= $signed({1'b0, gy_pos} - {1'b0, gy_neg});
      mag      <= abs_gx + abs_gy;
      vsync_s  <= {vsync_s[2:0], bus.per_frame_vsync};
      href_s   <= {href_s[2:0], bus.per_frame_href};
      clken_s  <= {clken_s[2:0], bus.per_frame_clken};
      border_s <= {border_s[1:0], border_in};
      // Results only move when a strobe reaches the output, so gaps hold the last value.
      if (clken_s[2]) begin
        if (border_s[2]) begin
          mag_out <= 8'd0;
          bit_out <= 8'h00;
        end else begin
          mag_out <= (mag > 11'd255) ? 8'd255 : mag[7:0];
          bit_out <= (mag > THRESHOLD) ? 8'hFF : 8'h00;
        end
      end
    end
  end

  assign bus.post_frame_vsync = vsync_s[3];
  assign bus.post_frame_href  = href_s[3];
  assign bus.post_frame_clken = clken_s[3];
  assign bus.post_img_mag     = mag_out;
  assign bus.post_img_bit     = bit_out;

endmodule

// File: tb/tb_sobel_edge_detect.sv
// tb/tb_sobel_edge_detect.sv - directed-vector bench for sobel_edge_detect
module tb_sobel_edge_detect;

  logic clock;
  logic sys_rst_n;
  sobel_edge_detect_if bus();

  sobel_edge_detect #(.THRESHOLD(11'd40), .LINE_CNT_W(11)) dut (
    .clock     (clock),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int sync_from = 1 << 30;

  bit vs_hist [4096];
  bit hs_hist [4096];
  bit ck_hist [4096];

  int         pix_q [$];
  logic [7:0] res_mag_q [$];
  logic [7:0] res_bit_q [$];
  int         res_cyc_q [$];

  // byte c of each 64-bit row word is the pixel at column c
  localparam logic [63:0] EDGE_UP   = 64'hFFFF_FFFF_0000_0000;
  localparam logic [63:0] EDGE_DN   = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] FLAT      = 64'h6464_6464_6464_6464;
  localparam logic [63:0] THR_A     = 64'h1E1E_1414_0A0A_0000;
  localparam logic [63:0] THR_B     = 64'h1E1D_1414_0A09_0000;
  localparam logic [63:0] SAT_R1    = 64'h4040_4040_3F3F_3F3F;
  localparam logic [63:0] ZERO      = 64'h0;
  localparam logic [63:0] EDGE_EXP  = 64'h0000_FFFF_0000_0000;
  localparam logic [63:0] THR_MAG   = 64'h2826_282A_2826_0000;
  localparam logic [63:0] THR_BIT   = 64'h0000_00FF_0000_0000;
  localparam logic [63:0] SAT_MAG   = 64'hFFFF_FFFE_FCFC_0000;
  localparam logic [63:0] SAT_BIT   = 64'hFFFF_FFFF_FFFF_0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) begin
    vs_hist[cyc & 4095] = bus.per_frame_vsync;
    hs_hist[cyc & 4095] = bus.per_frame_href;
    ck_hist[cyc & 4095] = bus.per_frame_clken;
    if (sys_rst_n && bus.per_frame_clken && bus.per_frame_href)
      pix_q.push_back(cyc);
    cyc = cyc + 1;
  end

  always @(negedge clock) begin
    if (sys_rst_n && cyc >= sync_from)
      check("sync", {bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken},
            {vs_hist[(cyc - 4) & 4095], hs_hist[(cyc - 4) & 4095], ck_hist[(cyc - 4) & 4095]});
    if (bus.post_frame_clken) begin
      res_mag_q.push_back(bus.post_img_mag);
      res_bit_q.push_back(bus.post_img_bit);
      res_cyc_q.push_back(cyc);
    end
  end

  task automatic idle_inputs(input logic vsync);
    bus.per_frame_vsync = vsync;
    bus.per_frame_href  = 1'b0;
    bus.per_frame_clken = 1'b0;
    bus.row1_data = 8'd0;
    bus.row2_data = 8'd0;
    bus.row3_data = 8'd0;
  endtask

  task automatic drive_px(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    bus.per_frame_href  = 1'b1;
    bus.per_frame_clken = 1'b1;
    bus.row1_data = a;
    bus.row2_data = b;
    bus.row3_data = c;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken,
                bus.post_img_mag, bus.post_img_bit});
  endfunction

  task automatic clear_queues();
    pix_q.delete();
    res_mag_q.delete();
    res_bit_q.delete();
    res_cyc_q.delete();
  endtask

  task automatic run_line(input string tag, input logic [63:0] r1, input logic [63:0] r2,
                          input logic [63:0] r3, input int gap,
                          input logic [63:0] em, input logic [63:0] eb);
    int t;
    int n;
    int pc;
    int oc;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      drive_px(r1[c*8 +: 8], r2[c*8 +: 8], r3[c*8 +: 8]);
      for (int g = 0; g < gap; g++) begin
        @(negedge clock);
        bus.per_frame_clken = 1'b0;
      end
    end
    @(negedge clock);
    idle_inputs(1'b1);
    t = 0;
    while (res_mag_q.size() < 8 && t < 40) begin
      @(negedge clock);
      t++;
    end
    @(negedge clock);
    check($sformatf("%s/count", tag), res_mag_q.size(), 8);
    n = (res_mag_q.size() < pix_q.size()) ? res_mag_q.size() : pix_q.size();
    if (n > 8) n = 8;
    for (int c = 0; c < n; c++) begin
      pc = pix_q.pop_front();
      oc = res_cyc_q.pop_front();
      check($sformatf("%s/mag%0d", tag, c), res_mag_q.pop_front(), em[c*8 +: 8]);
      check($sformatf("%s/bit%0d", tag, c), res_bit_q.pop_front(), eb[c*8 +: 8]);
      check($sformatf("%s/lat%0d", tag, c), oc - pc, 4);
    end
    clear_queues();
  endtask

  initial begin
    sys_rst_n = 1'b0;
    idle_inputs(1'b0);

    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      bus.per_frame_vsync = 1'($urandom);
      bus.per_frame_href  = 1'($urandom);
      bus.per_frame_clken = 1'($urandom);
      bus.row1_data = 8'($urandom);
      bus.row2_data = 8'($urandom);
      bus.row3_data = 8'($urandom);
      #1 check($sformatf("rst_hold%0d", i), all_outs(), 0);
    end
    @(negedge clock);
    idle_inputs(1'b0);
    sys_rst_n = 1'b1;
    sync_from = cyc + 4;
    clear_queues();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("rst_release%0d", i), all_outs(), 0);
    end

    @(negedge clock);
    idle_inputs(1'b1);
    repeat (2) @(negedge clock);

    run_line("l0_flat",   FLAT,    FLAT,  FLAT,    0, ZERO,     ZERO);
    run_line("l1_border", EDGE_UP, EDGE_UP, EDGE_UP, 0, ZERO,   ZERO);
    run_line("l2_flat",   FLAT,    FLAT,  FLAT,    0, ZERO,     ZERO);
    run_line("edge",      EDGE_UP, EDGE_UP, EDGE_UP, 0, EDGE_EXP, EDGE_EXP);
    run_line("edge_gap",  EDGE_UP, EDGE_UP, EDGE_UP, 2, EDGE_EXP, EDGE_EXP);
    run_line("edge_neg",  EDGE_DN, EDGE_DN, EDGE_DN, 0, EDGE_EXP, EDGE_EXP);
    run_line("thresh",    THR_A,   THR_B, THR_A,   0, THR_MAG,  THR_BIT);
    run_line("saturate",  SAT_R1,  ZERO,  ZERO,    0, SAT_MAG,  SAT_BIT);

    // mid-line reset: col3 result is on the outputs, cols 4-6 still in flight
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      drive_px(SAT_R1[c*8 +: 8], 8'd0, 8'd0);
    end
    @(negedge clock);
    check("pre_rst_mag", bus.post_img_mag, 8'hFC);
    sync_from = 1 << 30;
    sys_rst_n = 1'b0;
    idle_inputs(1'b0);
    #1 check("async_rst", all_outs(), 0);
    repeat (3) @(negedge clock);
    clear_queues();
    sys_rst_n = 1'b1;
    sync_from = cyc + 4;
    repeat (3) @(negedge clock);
    check("post_rst_quiet", all_outs(), 0);
    idle_inputs(1'b1);
    repeat (2) @(negedge clock);

    run_line("r_l0", EDGE_UP, EDGE_UP, EDGE_UP, 0, ZERO,     ZERO);
    run_line("r_l1", EDGE_UP, EDGE_UP, EDGE_UP, 1, ZERO,     ZERO);
    run_line("r_l2", EDGE_UP, EDGE_UP, EDGE_UP, 0, EDGE_EXP, EDGE_EXP);

    @(negedge clock);
    idle_inputs(1'b0);
    repeat (6) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
